// File: rtl/sram_controller_if.sv
// Pipeline-side load/store request bus for the SRAM controller.
// The memory stage is the master; the controller is the slave.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit load/store to a 16-bit asynchronous SRAM, two half-word
// accesses per word; ready stalls the pipeline while busy.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N
);
    typedef enum logic [3:0] {
        IDLE, W_TA, W_LO, W_HI,
        R_LO_A, R_LO_D, R_HI_A, R_HI_D,
        DONE
    } state_t;

    // Addresses are word-aligned, so an unaligned base only borrows one word.
    localparam logic [16:0] BASE_WORD = BASE_ADDR[18:2];
    localparam logic [16:0] BORROW    = {16'b0, |BASE_ADDR[1:0]};

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_word;
    logic [31:0] r_data;
    logic [31:0] r_rdata;
    logic [16:0] w_off;
    logic        w_start;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;
    logic        w_we_n;
    logic [17:0] w_addr;
    logic        w_ready;

    assign w_start = (r_state == IDLE) && (bus.wr_en || bus.rd_en);
    assign w_off   = r_word - BASE_WORD - BORROW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_word <= bus.address[18:2];
                r_data <= bus.write_data;
            end
            if (r_state == R_LO_D) r_rdata[15:0]  <= SRAM_DQ;
            if (r_state == R_HI_D) r_rdata[31:16] <= SRAM_DQ;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_addr   = '0;
        w_we_n   = 1'b1;
        w_dq_oe  = 1'b0;
        w_dq_out = '0;
        w_ready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = !(bus.wr_en || bus.rd_en);
                if (bus.wr_en)      w_next = W_TA;
                else if (bus.rd_en) w_next = R_LO_A;
            end
            // Device may still be driving DQ from the last read cycle.
            W_TA: begin
                w_addr = {w_off, 1'b0};
                w_we_n = 1'b0;
                w_next = W_LO;
            end
            W_LO: begin
                w_addr   = {w_off, 1'b0};
                w_we_n   = 1'b0;
                w_dq_oe  = 1'b1;
                w_dq_out = r_data[15:0];
                w_next   = W_HI;
            end
            W_HI: begin
                w_addr   = {w_off, 1'b1};
                w_we_n   = 1'b0;
                w_dq_oe  = 1'b1;
                w_dq_out = r_data[31:16];
                w_next   = DONE;
            end
            R_LO_A: begin
                w_addr = {w_off, 1'b0};
                w_next = R_LO_D;
            end
            R_LO_D: begin
                w_addr = {w_off, 1'b0};
                w_next = R_HI_A;
            end
            R_HI_A: begin
                w_addr = {w_off, 1'b1};
                w_next = R_HI_D;
            end
            R_HI_D: begin
                w_addr = {w_off, 1'b1};
                w_next = DONE;
            end
            DONE: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign SRAM_DQ       = w_dq_oe ? w_dq_out : 16'bz;
    assign SRAM_ADDR     = w_addr;
    assign SRAM_WE_N     = w_we_n;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_OE_N     = 1'b0;
    assign bus.read_data = r_rdata;
    assign bus.ready     = w_ready;
endmodule
